// File: rtl/dual_port_memory_pipelined.sv
// Byte-addressable big-endian RAM: port A load/store, port B word fetch.
// Latency: LATENCY cycles from request accept edge to registered response.
// Backpressure: none; one request per port per cycle, every request answered.
module dual_port_memory_pipelined #(
    parameter int N       = 4096,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_write,
    input  logic [1:0]           a_tsize,
    input  logic                 a_unsigned,
    input  logic [$clog2(N)-1:0] a_address,
    input  logic [31:0]          a_wdata,
    output logic                 a_rvalid,
    output logic [31:0]          a_rdata,
    output logic                 a_error,
    input  logic                 b_req,
    input  logic [$clog2(N)-1:0] b_address,
    output logic                 b_rvalid,
    output logic [31:0]          b_rdata,
    output logic                 b_error
);
    localparam int AW = $clog2(N);

    localparam logic [1:0] TSIZE_BYTE = 2'd0;
    localparam logic [1:0] TSIZE_HALF = 2'd1;

    logic [7:0] mem [N];

    // Offsets wrap mod N through AW-bit arithmetic.
    logic [AW-1:0] a_addr1, a_addr2, a_addr3;
    logic [AW-1:0] b_addr1, b_addr2, b_addr3;
    logic [7:0]    a_b0, a_b1, a_b2, a_b3;
    logic [7:0]    b_b0, b_b1, b_b2, b_b3;

    assign a_addr1 = a_address + AW'(1);
    assign a_addr2 = a_address + AW'(2);
    assign a_addr3 = a_address + AW'(3);
    assign b_addr1 = b_address + AW'(1);
    assign b_addr2 = b_address + AW'(2);
    assign b_addr3 = b_address + AW'(3);

    assign a_b0 = mem[a_address];
    assign a_b1 = mem[a_addr1];
    assign a_b2 = mem[a_addr2];
    assign a_b3 = mem[a_addr3];
    assign b_b0 = mem[b_address];
    assign b_b1 = mem[b_addr1];
    assign b_b2 = mem[b_addr2];
    assign b_b3 = mem[b_addr3];

    logic        a_misaligned;
    logic        a_sign_fill;
    logic [31:0] a_load_dat;
    logic [31:0] a_resp_dat;
    logic        a_do_write;
    logic        b_misaligned;
    logic [31:0] b_resp_dat;

    always_comb begin
        a_misaligned = 1'b0;
        a_sign_fill  = 1'b0;
        a_load_dat   = {a_b0, a_b1, a_b2, a_b3};
        case (a_tsize)
            TSIZE_BYTE: begin
                a_sign_fill = ~a_unsigned & a_b0[7];
                a_load_dat  = {{24{a_sign_fill}}, a_b0};
            end
            TSIZE_HALF: begin
                a_misaligned = a_address[0];
                a_sign_fill  = ~a_unsigned & a_b0[7];
                a_load_dat   = {{16{a_sign_fill}}, a_b0, a_b1};
            end
            default: begin
                a_misaligned = |a_address[1:0];
            end
        endcase
    end

    assign a_resp_dat   = (a_write || a_misaligned) ? 32'h0 : a_load_dat;
    assign a_do_write   = a_req & a_write & ~a_misaligned & ~rst;
    assign b_misaligned = |b_address[1:0];
    assign b_resp_dat   = b_misaligned ? 32'h0 : {b_b0, b_b1, b_b2, b_b3};

    // Reads above are combinational on the pre-edge contents, so a same-edge
    // store is invisible to them and visible to any request one cycle later.
    always_ff @(posedge clk) begin
        if (a_do_write) begin
            case (a_tsize)
                TSIZE_BYTE: begin
                    mem[a_address] <= a_wdata[7:0];
                end
                TSIZE_HALF: begin
                    mem[a_address] <= a_wdata[15:8];
                    mem[a_addr1]   <= a_wdata[7:0];
                end
                default: begin
                    mem[a_address] <= a_wdata[31:24];
                    mem[a_addr1]   <= a_wdata[23:16];
                    mem[a_addr2]   <= a_wdata[15:8];
                    mem[a_addr3]   <= a_wdata[7:0];
                end
            endcase
        end
    end

    logic [LATENCY-1:0] a_vld_q, a_err_q, b_vld_q, b_err_q;
    logic [31:0]        a_dat_q [LATENCY];
    logic [31:0]        b_dat_q [LATENCY];

    // Stage 0 captures at the accept edge; invalid slots carry zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q <= '0;
            a_err_q <= '0;
            b_vld_q <= '0;
            b_err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                a_dat_q[i] <= '0;
                b_dat_q[i] <= '0;
            end
        end else begin
            a_vld_q[0] <= a_req;
            a_err_q[0] <= a_req & a_misaligned;
            a_dat_q[0] <= a_req ? a_resp_dat : 32'h0;
            b_vld_q[0] <= b_req;
            b_err_q[0] <= b_req & b_misaligned;
            b_dat_q[0] <= b_req ? b_resp_dat : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                a_vld_q[i] <= a_vld_q[i-1];
                a_err_q[i] <= a_err_q[i-1];
                a_dat_q[i] <= a_dat_q[i-1];
                b_vld_q[i] <= b_vld_q[i-1];
                b_err_q[i] <= b_err_q[i-1];
                b_dat_q[i] <= b_dat_q[i-1];
            end
        end
    end

    assign a_rvalid = a_vld_q[LATENCY-1];
    assign a_error  = a_err_q[LATENCY-1];
    assign a_rdata  = a_dat_q[LATENCY-1];
    assign b_rvalid = b_vld_q[LATENCY-1];
    assign b_error  = b_err_q[LATENCY-1];
    assign b_rdata  = b_dat_q[LATENCY-1];

endmodule

// File: tb/tb_dual_port_memory_pipelined.sv
// Bench for dual_port_memory_pipelined: LATENCY=1 (N=4096) and LATENCY=3 (N=64)
// instances, directed vector table, multi-cycle sequences and a random scoreboard.
module tb_dual_port_memory_pipelined;
    localparam int N1 = 4096;
    localparam int N3 = 64;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a1_req, a1_write, a1_uns, a1_rvalid, a1_error;
    logic [1:0]  a1_tsize;
    logic [11:0] a1_addr;
    logic [31:0] a1_wdata, a1_rdata;
    logic        b1_req, b1_rvalid, b1_error;
    logic [11:0] b1_addr;
    logic [31:0] b1_rdata;

    logic        a3_req, a3_write, a3_uns, a3_rvalid, a3_error;
    logic [1:0]  a3_tsize;
    logic [5:0]  a3_addr;
    logic [31:0] a3_wdata, a3_rdata;
    logic        b3_req, b3_rvalid, b3_error;
    logic [5:0]  b3_addr;
    logic [31:0] b3_rdata;

    dual_port_memory_pipelined #(.N(N1), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a1_req), .a_write(a1_write), .a_tsize(a1_tsize), .a_unsigned(a1_uns),
        .a_address(a1_addr), .a_wdata(a1_wdata),
        .a_rvalid(a1_rvalid), .a_rdata(a1_rdata), .a_error(a1_error),
        .b_req(b1_req), .b_address(b1_addr),
        .b_rvalid(b1_rvalid), .b_rdata(b1_rdata), .b_error(b1_error)
    );

    dual_port_memory_pipelined #(.N(N3), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .a_req(a3_req), .a_write(a3_write), .a_tsize(a3_tsize), .a_unsigned(a3_uns),
        .a_address(a3_addr), .a_wdata(a3_wdata),
        .a_rvalid(a3_rvalid), .a_rdata(a3_rdata), .a_error(a3_error),
        .b_req(b3_req), .b_address(b3_addr),
        .b_rvalid(b3_rvalid), .b_rdata(b3_rdata), .b_error(b3_error)
    );

    typedef struct {
        int          due;
        logic [31:0] dat;
        logic        err;
    } resp_t;

    typedef struct {
        logic        port_b;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        int          addr;
        logic [31:0] wdata;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic rst_seen = 1'b0;
    logic [7:0] m1 [N1];
    logic [7:0] m3 [N3];
    resp_t q [4][$];   // 0:a1 1:b1 2:a3 3:b3
    vec_t vecs [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rd(int d, int addr);
        logic [31:0] w;
        for (int k = 0; k < 4; k++)
            w[8*(3-k) +: 8] = (d == 0) ? m1[(addr + k) % N1] : m3[(addr + k) % N3];
        return w;
    endfunction

    function automatic resp_t eval(int lat, logic wr, logic [1:0] sz, logic uns,
                                   int addr, logic [31:0] bytes);
        resp_t r;
        int nb;
        longint v;
        nb = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
        r.due = cyc + lat - 1;
        r.err = (addr % nb) != 0;
        v = 0;
        for (int k = 0; k < nb; k++)
            v = v * 256 + longint'(bytes[8*(3-k) +: 8]);
        if (!uns && nb < 4 && v >= (longint'(1) << (8*nb - 1)))
            v = v + (longint'(1) << 32) - (longint'(1) << (8*nb));
        r.dat = (wr || r.err) ? 32'h0 : v[31:0];
        return r;
    endfunction

    task automatic mwrite(int d, int addr, logic [1:0] sz, logic [31:0] wd);
        int nb;
        nb = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
            if (d == 0) m1[(addr + k) % N1] = wd[8*(nb-1-k) +: 8];
            else        m3[(addr + k) % N3] = wd[8*(nb-1-k) +: 8];
        end
    endtask

    task automatic model_edge();
        resp_t ra, rb;
        cyc++;
        rst_seen = rst;
        if (rst) begin
            for (int c = 0; c < 4; c++) q[c].delete();
        end else begin
            if (a1_req) begin
                ra = eval(1, a1_write, a1_tsize, a1_uns, int'(a1_addr), rd(0, int'(a1_addr)));
                q[0].push_back(ra);
            end
            if (b1_req) begin
                rb = eval(1, 1'b0, SZ_WORD, 1'b1, int'(b1_addr), rd(0, int'(b1_addr)));
                q[1].push_back(rb);
            end
            if (a1_req && a1_write && !ra.err) mwrite(0, int'(a1_addr), a1_tsize, a1_wdata);
            if (a3_req) begin
                ra = eval(3, a3_write, a3_tsize, a3_uns, int'(a3_addr), rd(1, int'(a3_addr)));
                q[2].push_back(ra);
            end
            if (b3_req) begin
                rb = eval(3, 1'b0, SZ_WORD, 1'b1, int'(b3_addr), rd(1, int'(b3_addr)));
                q[3].push_back(rb);
            end
            if (a3_req && a3_write && !ra.err) mwrite(1, int'(a3_addr), a3_tsize, a3_wdata);
        end
    endtask

    task automatic check_chan(int ch, string nm, logic v, logic [31:0] d, logic e);
        resp_t r;
        if (rst_seen) begin
            chk({nm, " rst rvalid"}, 32'(v), 32'h0);
            chk({nm, " rst rdata"}, d, 32'h0);
            chk({nm, " rst error"}, 32'(e), 32'h0);
        end else if (q[ch].size() > 0 && q[ch][0].due == cyc) begin
            r = q[ch].pop_front();
            chk({nm, " rvalid"}, 32'(v), 32'h1);
            chk({nm, " rdata"}, d, r.dat);
            chk({nm, " error"}, 32'(e), 32'(r.err));
        end else begin
            chk({nm, " idle rvalid"}, 32'(v), 32'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_chan(0, "a1", a1_rvalid, a1_rdata, a1_error);
        check_chan(1, "b1", b1_rvalid, b1_rdata, b1_error);
        check_chan(2, "a3", a3_rvalid, a3_rdata, a3_error);
        check_chan(3, "b3", b3_rvalid, b3_rdata, b3_error);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        a1_req = 0; a1_write = 0; a1_tsize = SZ_WORD; a1_uns = 0; a1_addr = '0; a1_wdata = '0;
        b1_req = 0; b1_addr = '0;
        a3_req = 0; a3_write = 0; a3_tsize = SZ_WORD; a3_uns = 0; a3_addr = '0; a3_wdata = '0;
        b3_req = 0; b3_addr = '0;
    endtask

    task automatic set_a1(logic wr, logic [1:0] sz, logic uns, int addr, logic [31:0] wd);
        a1_req = 1; a1_write = wr; a1_tsize = sz; a1_uns = uns; a1_addr = addr[11:0]; a1_wdata = wd;
    endtask

    task automatic set_a3(logic wr, logic [1:0] sz, logic uns, int addr, logic [31:0] wd);
        a3_req = 1; a3_write = wr; a3_tsize = sz; a3_uns = uns; a3_addr = addr[5:0]; a3_wdata = wd;
    endtask

    function automatic vec_t mkvec(logic pb, logic wr, logic [1:0] sz, logic uns, int addr,
                                   logic [31:0] wd, logic [31:0] ed, logic ee);
        vec_t v;
        v.port_b = pb; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr;
        v.wdata = wd; v.exp_dat = ed; v.exp_err = ee;
        return v;
    endfunction

    function automatic int pick1();
        if ($urandom_range(0, 15) == 0) return N1 - 4 + int'($urandom_range(0, 3));
        return int'($urandom_range(0, 127));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("reset a1_rvalid", 32'(a1_rvalid), 32'h0);
        chk("reset b3_rvalid", 32'(b3_rvalid), 32'h0);
        rst = 1'b0;

        // Prefill the regions that later reads touch; dut3 words 0..4 hold 1..5.
        for (int i = 0; i < 32; i++) begin
            idle();
            set_a1(1, SZ_WORD, 0, 4 * i, $urandom);
            if (i < 16) set_a3(1, SZ_WORD, 0, 4 * i, (i < 5) ? 32'(i + 1) : $urandom);
            tick();
        end
        idle();
        tick();

        // Directed table on the LATENCY=1 instance.
        vecs.push_back(mkvec(0, 1, SZ_WORD, 0, 'h10, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mkvec(0, 0, SZ_WORD, 0, 'h10, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mkvec(1, 0, SZ_WORD, 0, 'h10, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mkvec(0, 0, SZ_BYTE, 0, 'h10, 0, 32'hFFFFFFDE, 0));
        vecs.push_back(mkvec(0, 0, SZ_BYTE, 1, 'h10, 0, 32'h000000DE, 0));
        vecs.push_back(mkvec(0, 0, SZ_HALF, 0, 'h12, 0, 32'hFFFFBEEF, 0));
        vecs.push_back(mkvec(0, 0, SZ_HALF, 1, 'h12, 0, 32'h0000BEEF, 0));
        vecs.push_back(mkvec(0, 0, SZ_BYTE, 1, 'h11, 0, 32'h000000AD, 0));
        vecs.push_back(mkvec(0, 1, SZ_WORD, 0, 'h11, 32'h55555555, 32'h0, 1));
        vecs.push_back(mkvec(0, 1, SZ_HALF, 0, 'h13, 32'h00007777, 32'h0, 1));
        vecs.push_back(mkvec(0, 0, SZ_WORD, 0, 'h11, 0, 32'h0, 1));
        vecs.push_back(mkvec(0, 0, SZ_HALF, 0, 'h13, 0, 32'h0, 1));
        vecs.push_back(mkvec(1, 0, SZ_WORD, 0, 'h02, 0, 32'h0, 1));
        vecs.push_back(mkvec(1, 0, SZ_WORD, 0, 'h11, 0, 32'h0, 1));
        vecs.push_back(mkvec(0, 0, SZ_WORD, 0, 'h10, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mkvec(0, 1, SZ_BYTE, 0, 'h13, 32'h000000AB, 32'h0, 0));
        vecs.push_back(mkvec(0, 0, SZ_WORD, 0, 'h10, 0, 32'hDEADBEAB, 0));
        vecs.push_back(mkvec(0, 1, SZ_HALF, 0, 'h12, 32'hFFFF1234, 32'h0, 0));
        vecs.push_back(mkvec(1, 0, SZ_WORD, 0, 'h10, 0, 32'hDEAD1234, 0));
        vecs.push_back(mkvec(0, 0, SZ_HALF, 0, 'h10, 0, 32'hFFFFDEAD, 0));
        vecs.push_back(mkvec(0, 0, SZ_BYTE, 0, 'h13, 0, 32'h00000034, 0));
        vecs.push_back(mkvec(0, 1, SZ_WORD, 0, N1 - 4, 32'h01020304, 32'h0, 0));
        vecs.push_back(mkvec(0, 0, SZ_WORD, 0, N1 - 4, 0, 32'h01020304, 0));
        vecs.push_back(mkvec(1, 0, SZ_WORD, 0, N1 - 4, 0, 32'h01020304, 0));
        vecs.push_back(mkvec(0, 0, SZ_BYTE, 1, N1 - 1, 0, 32'h00000004, 0));
        vecs.push_back(mkvec(0, 1, SZ_WORD, 0, 'h20, 32'h11111111, 32'h0, 0));

        foreach (vecs[i]) begin
            idle();
            if (vecs[i].port_b) begin
                b1_req = 1; b1_addr = vecs[i].addr[11:0];
            end else begin
                set_a1(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            end
            tick();
            if (vecs[i].port_b) begin
                chk($sformatf("vec%0d b rvalid", i), 32'(b1_rvalid), 32'h1);
                chk($sformatf("vec%0d b rdata", i), b1_rdata, vecs[i].exp_dat);
                chk($sformatf("vec%0d b error", i), 32'(b1_error), 32'(vecs[i].exp_err));
            end else begin
                chk($sformatf("vec%0d a rvalid", i), 32'(a1_rvalid), 32'h1);
                chk($sformatf("vec%0d a rdata", i), a1_rdata, vecs[i].exp_dat);
                chk($sformatf("vec%0d a error", i), 32'(a1_error), 32'(vecs[i].exp_err));
            end
        end

        // Same-cycle store/fetch collision, then store followed by next-cycle reads.
        idle();
        set_a1(1, SZ_WORD, 0, 'h20, 32'hCAFEF00D);
        b1_req = 1; b1_addr = 12'h020;
        tick();
        chk("collision b old data", b1_rdata, 32'h11111111);
        idle();
        set_a1(0, SZ_WORD, 0, 'h20, 0);
        b1_req = 1; b1_addr = 12'h020;
        tick();
        chk("next-cycle b new data", b1_rdata, 32'hCAFEF00D);
        chk("next-cycle a new data", a1_rdata, 32'hCAFEF00D);
        idle();
        tick();

        // LATENCY=3 back-to-back loads of 1..5.
        for (int t = 0; t < 9; t++) begin
            idle();
            if (t < 5) set_a3(0, SZ_WORD, 0, 4 * t, 0);
            tick();
            chk($sformatf("lat3 rvalid t%0d", t), 32'(a3_rvalid), 32'((t >= 2) && (t < 7)));
            if (t >= 2 && t < 7) chk($sformatf("lat3 rdata t%0d", t), a3_rdata, 32'(t - 1));
        end

        // Reset while two loads are in flight; a store during reset must not land.
        idle(); set_a3(0, SZ_WORD, 0, 0, 0); tick();
        idle(); set_a3(0, SZ_WORD, 0, 4, 0); tick();
        idle(); rst = 1'b1; set_a3(1, SZ_WORD, 0, 0, 32'h99999999); tick();
        chk("midflight rst rvalid", 32'(a3_rvalid), 32'h0);
        rst = 1'b0;
        idle();
        for (int t = 0; t < 6; t++) begin
            tick();
            chk($sformatf("flushed rvalid t%0d", t), 32'(a3_rvalid), 32'h0);
        end
        set_a3(0, SZ_WORD, 0, 0, 0); tick();
        idle(); tick(); tick();
        chk("after rst rvalid", 32'(a3_rvalid), 32'h1);
        chk("store in rst dropped", a3_rdata, 32'h00000001);

        // Random traffic on all four ports, occasional reset.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) != 0)
                set_a1(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), pick1(), $urandom);
            if ($urandom_range(0, 3) != 0) begin
                b1_req = 1;
                b1_addr = 12'(($urandom_range(0, 3) == 0) ? pick1() : (pick1() & ~3));
            end
            if ($urandom_range(0, 3) != 0)
                set_a3(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
                       int'($urandom_range(0, N3 - 1)), $urandom);
            if ($urandom_range(0, 3) != 0) begin
                b3_req = 1;
                b3_addr = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, N3 - 1)
                                                         : ($urandom_range(0, N3 - 1) & ~3));
            end
            tick();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) tick();
        chk("drain pending", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dual_port_memory_pipelined.md
Name: dual_port_memory_pipelined

Overview:
Parametrised byte-addressable RAM with one read/write data port (A) and one read-only fetch port (B). Each port has a request/response pipeline with configurable read latency. Loads can be sign- or zero-extended. Misaligned accesses are reported per request. It sits behind the core's load/store unit (A) and instruction fetch (B).

Parameters:
N, 4096, memory size in bytes; power of two, ≥ 8.
LATENCY, 1, read latency in cycles from request accept to response valid; legal range 1..4.
AW, $clog2(N), byte address width; derived, not overridden.

Ports:
clk  input  1  clock, all state on posedge.
rst  input  1  synchronous active-high reset.
a_req  input  1  port A request valid.
a_write  input  1  port A request is a store (1) or load (0).
a_tsize  input  tsize_e  access size: WORD, HALFWORD or BYTE.
a_unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend. Ignored for WORD and for stores.
a_address  input  AW  port A byte address.
a_wdata  input  32  store data, right-aligned (BYTE uses [7:0], HALFWORD uses [15:0]).
a_rvalid  output  1  port A response valid, one pulse per accepted request, including stores.
a_rdata  output  32  port A load data; 0 for stores and errors.
a_error  output  1  port A misaligned, qualified by a_rvalid.
b_req  input  1  port B fetch request valid.
b_address  input  AW  port B byte address; WORD access only.
b_rvalid  output  1  port B response valid.
b_rdata  output  32  port B fetch data; 0 on error.
b_error  output  1  port B misaligned (address[1:0] != 0), qualified by b_rvalid.

Behaviour:
- Storage: bit [7:0] mem[N]. Big-endian: a word at address x is {mem[x], mem[x+1], mem[x+2], mem[x+3]}; a halfword is {mem[x], mem[x+1]}. Contents are not cleared by reset.
- Alignment: WORD needs address[1:0]==0; HALFWORD needs address[0]==0; BYTE is always aligned.
- Misaligned request: no memory access and no write. It still produces one response with error=1 and rdata=0.
- Acceptance: every request is accepted in the cycle its req=1. There is no backpressure; one request per port per cycle.
- Store: bytes are written at the posedge where the request is accepted. The response appears LATENCY cycles later with rdata=0.
- Load: memory is sampled at the accept edge and the result is pushed through a LATENCY-stage valid/data/error shift pipeline. The response has rvalid=1 exactly LATENCY cycles after the accept edge.
- Extension: BYTE gives 24 bits of (a_unsigned ? 0 : bit7). HALFWORD gives 16 bits of (a_unsigned ? 0 : bit15).
- Back-to-back requests on every cycle give a response on every cycle, in order. The ports are fully independent.
- Same-cycle collision: if port B (or a port A load) reads bytes that a port A store writes in the same cycle, it returns the OLD data (read-before-write).
- A store followed by a load of the same address in the next cycle returns the NEW data.
- Address wrap: byte offsets +1..+3 are computed mod N. This is only reachable through an aligned word at N-4, so no real wrap occurs.
- Reset: while rst=1, a_rvalid, b_rvalid, a_error and b_error are 0, and a_rdata and b_rdata are 0. All pipeline stages are flushed and requests are ignored, with no write.
- Reset asserted mid-pipeline: in-flight responses are discarded and never emitted.
- First request is accepted in the cycle after rst is deasserted.
- Outputs are registered at the final pipeline stage; there is no combinational path from input to output.

Test Plan:
- LATENCY=1: store WORD 0xDEADBEEF at 0x10, then load WORD at 0x10 and fetch on B at 0x10. Expect a_rdata = b_rdata = 0xDEADBEEF, one cycle after each request, errors 0.
- Signed vs unsigned: load BYTE 0x10 with a_unsigned=0 -> 0xFFFFFFDE; with a_unsigned=1 -> 0x000000DE. Load HALFWORD 0x12 with a_unsigned=0 -> 0xFFFFBEEF.
- Misaligned: WORD at 0x11, HALFWORD at 0x13, and B fetch at 0x02. Each gives rvalid=1, error=1, rdata=0. Memory at 0x10..0x13 is unchanged.
- LATENCY=3: issue 5 back-to-back loads to addresses 0,4,8,12,16 preloaded with 1..5. Expect rvalid high for 5 consecutive cycles starting 3 cycles after the first request, with data 1..5 in order.
- Collision: in the same cycle, store A WORD 0xCAFEF00D at 0x20 (old value 0x11111111) and fetch B at 0x20. Expect b_rdata=0x11111111. A B fetch in the next cycle gives 0xCAFEF00D.
- Reset mid-flight (LATENCY=3): issue 2 loads, then assert rst for 1 cycle. Expect no rvalid pulses afterwards. A store issued during rst is not written (a later read returns the old value).
